// File: rtl/sync_fifo_mc_pkg.sv
// Shared types, constants and helpers for the multi-channel synchronous FIFO.
// level_t/ch_idx_t describe the default configuration; modules size from their parameters.
package sync_fifo_mc_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned DEF_CHANNELS   = 2;
  localparam int unsigned DROP_CNT_W     = 16;

  // Channel index width, never below one bit so a single-channel build still has a port.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

  typedef logic [clog2_min1(DEF_CHANNELS)-1:0] ch_idx_t;
  typedef logic [DEF_ADDR_WIDTH:0]             level_t;
  typedef logic [DROP_CNT_W-1:0]               drop_cnt_t;

endpackage

// File: rtl/sync_fifo_mc_if.sv
// Handshake/status bundle between the FIFO and its user.
// Carries drop_count only when SYNC_FIFO_MC_DROP_COUNT_EN is defined.
interface sync_fifo_mc_if
  import sync_fifo_mc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned CHANNELS   = 2
);
  localparam int unsigned CH_W = clog2_min1(CHANNELS);
  localparam int unsigned LW   = ADDR_WIDTH + 1;

  logic                     wr_en;
  logic [CH_W-1:0]          wr_ch;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic [CHANNELS-1:0]      full;
  logic                     rd_en;
  logic [CH_W-1:0]          rd_ch;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic                     rd_valid;
  logic [CHANNELS-1:0]      empty;
  logic [CHANNELS-1:0]      has_data;
  logic [CHANNELS*LW-1:0]   level;
  logic                     overflow;
  logic                     underflow;
`ifdef SYNC_FIFO_MC_DROP_COUNT_EN
  logic [CHANNELS*DROP_CNT_W-1:0] drop_count;
`endif

  modport master (
    output wr_en, wr_ch, wr_data, rd_en, rd_ch,
    input  full, rd_data, rd_valid, empty, has_data, level, overflow, underflow
`ifdef SYNC_FIFO_MC_DROP_COUNT_EN
    , input drop_count
`endif
  );

  modport slave (
    input  wr_en, wr_ch, wr_data, rd_en, rd_ch,
    output full, rd_data, rd_valid, empty, has_data, level, overflow, underflow
`ifdef SYNC_FIFO_MC_DROP_COUNT_EN
    , output drop_count
`endif
  );

endinterface

// File: rtl/sync_fifo_mc_ch_ctrl.sv
// Per-channel pointer/level bookkeeping, accept decisions and registered status flags.
// Optional saturating drop counter under SYNC_FIFO_MC_DROP_COUNT_EN.
module sync_fifo_mc_ch_ctrl
  import sync_fifo_mc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned RESERVE      = 0,
  parameter int unsigned HAS_DATA_MIN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic                  rd_req,
  output logic                  wr_accept_c,
  output logic                  rd_accept_c,
  output logic [ADDR_WIDTH-1:0] wr_ptr_q,
  output logic [ADDR_WIDTH-1:0] rd_ptr_q,
  output logic [ADDR_WIDTH:0]   level_q,
  output logic                  full_q,
  output logic                  empty_q,
  output logic                  has_data_q
`ifdef SYNC_FIFO_MC_DROP_COUNT_EN
  ,
  output drop_cnt_t             drop_cnt_q
`endif
);
  localparam int unsigned LW    = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] wr_ptr_d, rd_ptr_d;
  logic [LW-1:0]         level_d;
  logic                  full_d, empty_d, has_data_d;
`ifdef SYNC_FIFO_MC_DROP_COUNT_EN
  drop_cnt_t             drop_cnt_d;
`endif

  // Acceptance looks only at the pre-edge level: no pass-through between read and write.
  always_comb begin : next_state
    wr_accept_c = wr_req && (level_q < LW'(DEPTH));
    rd_accept_c = rd_req && (level_q != '0);
    wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(wr_accept_c);
    rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(rd_accept_c);
    level_d     = level_q + LW'(wr_accept_c) - LW'(rd_accept_c);
    full_d      = (LW'(DEPTH) - level_d) <= LW'(RESERVE);
    empty_d     = (level_d == '0);
    has_data_d  = (level_d >= LW'(HAS_DATA_MIN));
`ifdef SYNC_FIFO_MC_DROP_COUNT_EN
    drop_cnt_d  = drop_cnt_q;
    if (wr_req && !wr_accept_c && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
`endif
  end

  always_ff @(posedge clk) begin : state_reg
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      has_data_q <= 1'b0;
`ifdef SYNC_FIFO_MC_DROP_COUNT_EN
      drop_cnt_q <= '0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      has_data_q <= has_data_d;
`ifdef SYNC_FIFO_MC_DROP_COUNT_EN
      drop_cnt_q <= drop_cnt_d;
`endif
    end
  end

endmodule

// File: rtl/sync_fifo_mc.sv
// Single-clock multi-channel FIFO: one shared RAM split into per-channel regions.
// Define SYNC_FIFO_MC_DROP_COUNT_EN to add per-channel dropped-write counters.
module sync_fifo_mc
  import sync_fifo_mc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned RESERVE      = 0,
  parameter int unsigned HAS_DATA_MIN = 1
) (
  input  logic          clk,
  input  logic          rst,
  sync_fifo_mc_if.slave bus
);
  localparam int unsigned LW        = ADDR_WIDTH + 1;
  localparam int unsigned CH_W      = clog2_min1(CHANNELS);
  localparam int unsigned RAM_AW    = CH_W + ADDR_WIDTH;
  localparam int unsigned RAM_WORDS = 1 << RAM_AW;

  logic [CHANNELS-1:0]    wr_req_c, rd_req_c, wr_acc_c, rd_acc_c;
  logic [CHANNELS-1:0]    full_q, empty_q, has_data_q;
  logic [ADDR_WIDTH-1:0]  wr_ptr_q [CHANNELS];
  logic [ADDR_WIDTH-1:0]  rd_ptr_q [CHANNELS];
  logic [LW-1:0]          level_q  [CHANNELS];
  logic [ADDR_WIDTH-1:0]  wr_ptr_sel_c, rd_ptr_sel_c;
  logic [RAM_AW-1:0]      wr_addr_c, rd_addr_c;
  logic [CHANNELS*LW-1:0] level_vec_c;
  logic [DATA_WIDTH-1:0]  mem [RAM_WORDS];
  logic [DATA_WIDTH-1:0]  rd_data_d, rd_data_q;
  logic                   rd_valid_d, rd_valid_q;
  logic                   overflow_d, overflow_q;
  logic                   underflow_d, underflow_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    sync_fifo_mc_ch_ctrl #(
      .ADDR_WIDTH   (ADDR_WIDTH),
      .RESERVE      (RESERVE),
      .HAS_DATA_MIN (HAS_DATA_MIN)
    ) u_ctrl (
      .clk         (clk),
      .rst         (rst),
      .wr_req      (wr_req_c[c]),
      .rd_req      (rd_req_c[c]),
      .wr_accept_c (wr_acc_c[c]),
      .rd_accept_c (rd_acc_c[c]),
      .wr_ptr_q    (wr_ptr_q[c]),
      .rd_ptr_q    (rd_ptr_q[c]),
      .level_q     (level_q[c]),
      .full_q      (full_q[c]),
      .empty_q     (empty_q[c]),
      .has_data_q  (has_data_q[c])
`ifdef SYNC_FIFO_MC_DROP_COUNT_EN
      ,
      .drop_cnt_q  (bus.drop_count[c*DROP_CNT_W +: DROP_CNT_W])
`endif
    );
  end

  // Channel decode; out-of-range channel indices match no controller and are ignored silently.
  always_comb begin : ch_decode
    wr_req_c     = '0;
    rd_req_c     = '0;
    wr_ptr_sel_c = '0;
    rd_ptr_sel_c = '0;
    level_vec_c  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      wr_req_c[c] = bus.wr_en && (bus.wr_ch == CH_W'(c));
      rd_req_c[c] = bus.rd_en && (bus.rd_ch == CH_W'(c));
      if (wr_req_c[c]) wr_ptr_sel_c = wr_ptr_q[c];
      if (rd_req_c[c]) rd_ptr_sel_c = rd_ptr_q[c];
      level_vec_c[c*LW +: LW] = level_q[c];
    end
    wr_addr_c = {bus.wr_ch, wr_ptr_sel_c};
    rd_addr_c = {bus.rd_ch, rd_ptr_sel_c};
  end

  always_comb begin : out_next
    rd_valid_d  = |rd_acc_c;
    rd_data_d   = rd_data_q;
    if (rd_valid_d) rd_data_d = mem[rd_addr_c];
    overflow_d  = |(wr_req_c & ~wr_acc_c);
    underflow_d = |(rd_req_c & ~rd_acc_c);
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin : ram_write
    if (!rst && (|wr_acc_c)) mem[wr_addr_c] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin : out_reg
    if (rst) begin
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.has_data  = has_data_q;
  assign bus.level     = level_vec_c;

endmodule

// File: tb/tb_sync_fifo_mc.sv
// Self-checking bench for sync_fifo_mc: queue model per channel plus a read-data scoreboard.
module tb_sync_fifo_mc;
  import sync_fifo_mc_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned CH    = 2;
  localparam int unsigned RES   = 8;
  localparam int unsigned HDM   = 1;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW    = AW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_mc_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CHANNELS(CH)) bus ();

  sync_fifo_mc #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CHANNELS(CH), .RESERVE(RES), .HAS_DATA_MIN(HDM)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  mq [CH][$];
  logic [7:0]  exp_q [$];
  logic [7:0]  last_rd;
  int unsigned dc [CH];
  int          of_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, update the model with pre-edge acceptance, then check after the edge.
  task automatic cycle(input logic do_rst, input logic we, input int wch, input int wd,
                       input logic re, input int rch);
    logic wa, drop, ra, uf;
    int   sz;
    rst         = do_rst;
    bus.wr_en   = we;
    bus.wr_ch   = 1'(wch);
    bus.wr_data = 8'(wd);
    bus.rd_en   = re;
    bus.rd_ch   = 1'(rch);
    wa = 1'b0; drop = 1'b0; ra = 1'b0; uf = 1'b0;
    if (do_rst) begin
      for (int c = 0; c < CH; c++) begin
        mq[c].delete();
        dc[c] = 0;
      end
      exp_q.delete();
      last_rd = '0;
    end else begin
      if (we) begin
        wa   = (mq[wch].size() < DEPTH);
        drop = !wa;
      end
      if (re) begin
        if (mq[rch].size() != 0) begin
          ra = 1'b1;
          exp_q.push_back(mq[rch].pop_front());
        end else begin
          uf = 1'b1;
        end
      end
      if (wa) mq[wch].push_back(8'(wd));
      if (drop && dc[wch] < 65535) dc[wch]++;
    end
    @(posedge clk);
    #1;
    check("rd_valid", 32'(bus.rd_valid), 32'(ra));
    check("overflow", 32'(bus.overflow), 32'(drop));
    check("underflow", 32'(bus.underflow), 32'(uf));
    if (ra) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'(1), 32'(0));
      end else begin
        last_rd = exp_q.pop_front();
        check("rd_data", 32'(bus.rd_data), 32'(last_rd));
      end
    end else begin
      check("rd_data_hold", 32'(bus.rd_data), 32'(last_rd));
    end
    for (int c = 0; c < CH; c++) begin
      sz = mq[c].size();
      check($sformatf("level%0d", c), 32'(bus.level[c*LW +: LW]), 32'(sz));
      check($sformatf("empty%0d", c), 32'(bus.empty[c]), 32'(sz == 0));
      check($sformatf("full%0d", c), 32'(bus.full[c]), 32'((DEPTH - sz) <= RES));
      check($sformatf("has_data%0d", c), 32'(bus.has_data[c]), 32'(sz >= HDM));
`ifdef SYNC_FIFO_MC_DROP_COUNT_EN
      check($sformatf("drop_count%0d", c), 32'(bus.drop_count[c*16 +: 16]), dc[c]);
`endif
    end
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 0, 0, 1'b0, 0);
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_data = '0; bus.rd_en = 1'b0; bus.rd_ch = '0;
    last_rd = '0;

    // Reset, then idle.
    cycle(1'b1, 1'b0, 0, 0, 1'b0, 0);
    for (int i = 0; i < 20; i++) idle();

    // Fill ch0 past capacity, then drain in order.
    of_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1, 0, i, 1'b0, 0);
      of_cnt += int'(bus.overflow);
      if (i == 6) check("full0_after7", 32'(bus.full[0]), 32'(0));
      if (i == 7) check("full0_after8", 32'(bus.full[0]), 32'(1));
    end
    check("overflow_pulses", 32'(of_cnt), 32'(4));
    check("level0_filled", 32'(bus.level[0 +: LW]), 32'(16));
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 0, 0, 1'b1, 0);
    idle();
    check("empty0_drained", 32'(bus.empty[0]), 32'(1));

    // Interleaved writes, alternating reads.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 0, 8'h10 + i, 1'b0, 0);
      cycle(1'b0, 1'b1, 1, 8'h20 + i, 1'b0, 0);
    end
    check("level0_il", 32'(bus.level[0 +: LW]), 32'(5));
    check("level1_il", 32'(bus.level[LW +: LW]), 32'(5));
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 0, 0, 1'b1, i % 2);
    idle();

    // Simultaneous read+write on a full channel, then on a partially filled one.
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 0, 8'h40 + i, 1'b0, 0);
    cycle(1'b0, 1'b1, 0, 8'hEE, 1'b1, 0);
    check("level0_rw_full", 32'(bus.level[0 +: LW]), 32'(15));
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 0, 0, 1'b1, 0);
    cycle(1'b0, 1'b1, 0, 8'hAB, 1'b1, 0);
    check("level0_rw_mid", 32'(bus.level[0 +: LW]), 32'(3));
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 0, 0, 1'b1, 0);
    check("last_word_ab", 32'(bus.rd_data), 32'(8'hAB));
    idle();

    // Underflow on empty ch1, then reset mid-operation.
    cycle(1'b0, 1'b0, 0, 0, 1'b1, 1);
    check("underflow_pulse", 32'(bus.underflow), 32'(1));
    idle();
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 0, 8'h60 + i, 1'b0, 0);
    check("level0_pre_rst", 32'(bus.level[0 +: LW]), 32'(7));
    cycle(1'b1, 1'b1, 0, 8'h99, 1'b1, 0);
    check("level0_post_rst", 32'(bus.level[0 +: LW]), 32'(0));
    check("empty0_post_rst", 32'(bus.empty[0]), 32'(1));
    cycle(1'b0, 1'b1, 0, 8'h5A, 1'b0, 0);
    cycle(1'b0, 1'b0, 0, 0, 1'b1, 0);
    check("post_rst_data", 32'(bus.rd_data), 32'(8'h5A));
    idle();

`ifdef SYNC_FIFO_MC_DROP_COUNT_EN
    // Dropped-write counters.
    cycle(1'b1, 1'b0, 0, 0, 1'b0, 0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 0, i, 1'b0, 0);
    check("drop_count0_is4", 32'(bus.drop_count[0 +: 16]), 32'(4));
    check("drop_count1_is0", 32'(bus.drop_count[16 +: 16]), 32'(0));
    cycle(1'b1, 1'b0, 0, 0, 1'b0, 0);
    check("drop_count0_rst", 32'(bus.drop_count[0 +: 16]), 32'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule
